mem_access_stage: RTL and testbench

//  MEM stage between the EX/MEM and MEM/WB pipeline registers. Runs loads and stores on a req/gnt/rvalid data bus.

---
 rtl/mem_access_stage.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/gnt/rvalid bus, steers store lanes,
// extends load data, drops misaligned accesses and aborts on bus timeout.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_stall,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              dmem_req_reg, dmem_req_next;
  logic              dmem_we_reg, dmem_we_next;
  logic [31:0]       dmem_addr_reg, dmem_addr_next;
  logic [31:0]       dmem_wdata_reg, dmem_wdata_next;
  logic [3:0]        dmem_wstrb_reg, dmem_wstrb_next;
  logic [31:0]       alu_reg, alu_next;
  logic [4:0]        rd_reg, rd_next;
  logic              reg_write_reg, reg_write_next;
  logic              mem_to_reg_reg, mem_to_reg_next;
  logic [2:0]        funct3_reg, funct3_next;
  logic              is_load_reg, is_load_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic              mem_op;
  logic              misaligned;
  logic              timeout;
  logic [1:0]        size;
  logic [1:0]        lane;
  logic [3:0][7:0]   wdata_steer;
  logic [3:0]        wstrb_steer;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  assign size   = funct3_in[1:0];
  assign lane   = alu_result_in[1:0];
  assign mem_op = valid_in & (mem_read_in | mem_write_in);

  always_comb begin
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_in[0];
      default: misaligned = |alu_result_in[1:0];
    endcase
  end

  // Each byte lane picks its store byte and strobe independently of the others.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign wstrb_steer[gi] = (size == 2'b00) ? (lane == LANE) :
                             (size == 2'b01) ? (alu_result_in[1] == LANE[1]) : 1'b1;
    assign wdata_steer[gi] = (size == 2'b00) ? write_data_in[7:0] :
                             (size == 2'b01) ? write_data_in[8*(gi%2) +: 8] :
                                               write_data_in[8*gi +: 8];
  end

  // Load extraction uses the latched address and funct3, not the (possibly stale) inputs.
  assign byte_sel = dmem_rdata[{alu_reg[1:0], 3'b000} +: 8];
  assign half_sel = alu_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  assign timeout = TO_EN && (cnt_reg == TO_LAST);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    dmem_req_next   = dmem_req_reg;
    dmem_we_next    = dmem_we_reg;
    dmem_addr_next  = dmem_addr_reg;
    dmem_wdata_next = dmem_wdata_reg;
    dmem_wstrb_next = dmem_wstrb_reg;
    alu_next        = alu_reg;
    rd_next         = rd_reg;
    reg_write_next  = reg_write_reg;
    mem_to_reg_next = mem_to_reg_reg;
    funct3_next     = funct3_reg;
    is_load_next    = is_load_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;

    mem_stall       = 1'b0;
    misaligned_out  = 1'b0;
    bus_error_out   = 1'b0;
    reg_write_out   = reg_write_in;
    mem_to_reg_out  = mem_to_reg_in;
    read_data_out   = 32'b0;
    alu_result_out  = alu_result_in;
    rd_out          = rd_in;

    case (state_reg)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            misaligned_out = 1'b1;
            reg_write_out  = 1'b0;
          end else begin
            mem_stall       = 1'b1;
            state_next      = S_REQ;
            cnt_next        = '0;
            alu_next        = alu_result_in;
            rd_next         = rd_in;
            reg_write_next  = reg_write_in;
            mem_to_reg_next = mem_to_reg_in;
            funct3_next     = funct3_in;
            is_load_next    = mem_read_in;
            rdata_next      = 32'b0;
            err_next        = 1'b0;
            dmem_req_next   = 1'b1;
            dmem_we_next    = mem_write_in;
            dmem_addr_next  = {alu_result_in[31:2], 2'b00};
            dmem_wdata_next = mem_write_in ? wdata_steer : 32'b0;
            dmem_wstrb_next = mem_write_in ? wstrb_steer : 4'b0000;
          end
        end
      end

      S_REQ: begin
        mem_stall      = 1'b1;
        mem_to_reg_out = mem_to_reg_reg;
        alu_result_out = alu_reg;
        rd_out         = rd_reg;
        if (dmem_gnt) begin
          dmem_req_next = 1'b0;
          cnt_next      = '0;
          if (!is_load_reg) begin
            state_next = S_DONE;
          end else if (dmem_rvalid) begin
            rdata_next = load_ext;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
          end
        end else if (timeout) begin
          dmem_req_next = 1'b0;
          bus_error_out = 1'b1;
          err_next      = 1'b1;
          cnt_next      = '0;
          state_next    = S_DONE;
        end else if (TO_EN) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_WAIT: begin
        mem_stall      = 1'b1;
        mem_to_reg_out = mem_to_reg_reg;
        alu_result_out = alu_reg;
        rd_out         = rd_reg;
        if (dmem_rvalid) begin
          rdata_next = load_ext;
          cnt_next   = '0;
          state_next = S_DONE;
        end else if (timeout) begin
          bus_error_out = 1'b1;
          err_next      = 1'b1;
          cnt_next      = '0;
          state_next    = S_DONE;
        end else if (TO_EN) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_DONE: begin
        reg_write_out  = reg_write_reg & ~err_reg;
        mem_to_reg_out = mem_to_reg_reg;
        read_data_out  = err_reg ? 32'b0 : rdata_reg;
        alu_result_out = alu_reg;
        rd_out         = rd_reg;
        state_next     = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    if (mem_stall) reg_write_out = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= 32'b0;
      dmem_wdata_reg <= 32'b0;
      dmem_wstrb_reg <= 4'b0;
      alu_reg        <= 32'b0;
      rd_reg         <= 5'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      funct3_reg     <= 3'b0;
      is_load_reg    <= 1'b0;
      rdata_reg      <= 32'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      dmem_req_reg   <= dmem_req_next;
      dmem_we_reg    <= dmem_we_next;
      dmem_addr_reg  <= dmem_addr_next;
      dmem_wdata_reg <= dmem_wdata_next;
      dmem_wstrb_reg <= dmem_wstrb_next;
      alu_reg        <= alu_next;
      rd_reg         <= rd_next;
      reg_write_reg  <= reg_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
      funct3_reg     <= funct3_next;
      is_load_reg    <= is_load_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
    end
  end

  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_we_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;
  assign dmem_wstrb = dmem_wstrb_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: acts as the data-bus slave and compares each
// instruction's outcome against a transaction-level model of the MEM stage.
module tb_mem_access_stage;

  localparam int TO    = 16;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_to_reg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_write_out, mem_to_reg_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  rd_out;
  logic        mem_stall, misaligned_out, bus_error_out;

  int checks_total  = 0;
  int checks_passed = 0;
  int op_num        = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out), .rd_out(rd_out),
    .mem_stall(mem_stall), .misaligned_out(misaligned_out), .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (op %0d)", tag, got, exp, op_num);
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    logic [31:0] bt, hf;
    bt = (word >> (8 * (addr % 4))) % 256;
    hf = (word >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (bt >= 128) ? bt - 256 : bt;
      3'd4:    return bt;
      3'd1:    return (hf >= 32768) ? hf - 65536 : hf;
      3'd5:    return hf;
      default: return word;
    endcase
  endfunction

  // g: REQ cycles before gnt (>=TO: never). r: WAIT cycles before rvalid (-1: with gnt, >=TO: never).
  task automatic run_op(input bit vld, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input bit rw, input bit m2r, input logic [31:0] word,
                        input int g, input int r);
    int sz, exp_stall, stall, errs, req_cnt, wait_cnt, cyc;
    bit memop, mis, aligned, exp_err, granted, data_given, finished, req_seen, rw_bad;
    logic [31:0] exp_rdata, exp_wdata, strb_w;

    memop = vld && (ld || st);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = memop && ((addr % sz) != 0);
    aligned = memop && !mis;
    exp_err = aligned && ((g >= TO) || (ld && r >= TO));
    if (!aligned)     exp_stall = 0;
    else if (g >= TO) exp_stall = 1 + TO;
    else if (st || r < 0) exp_stall = 1 + g + 1;
    else if (r >= TO) exp_stall = 1 + g + 1 + TO;
    else              exp_stall = 1 + g + 1 + r + 1;
    exp_rdata = (aligned && ld && !exp_err) ? load_model(word, addr, f3) : 32'd0;
    exp_wdata = (sz == 1) ? (wd % 256) * 32'h0101_0101 :
                (sz == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
    strb_w = ((32'd1 << sz) - 1) << (addr % 4);

    valid_in = vld; mem_read_in = ld; mem_write_in = st; funct3_in = f3;
    alu_result_in = addr; write_data_in = wd; rd_in = rd;
    reg_write_in = rw; mem_to_reg_in = m2r;

    stall = 0; errs = 0; req_cnt = 0; wait_cnt = 0; cyc = 0;
    granted = 0; data_given = 0; finished = 0; req_seen = 0; rw_bad = 0;
    while (!finished) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      if (dmem_req) begin
        if (!req_seen) begin
          req_seen = 1;
          check("bus_addr", dmem_addr, addr - (addr % 4));
          check("bus_we", 32'(dmem_we), 32'(st));
          if (st) begin
            check("bus_wdata", dmem_wdata, exp_wdata);
            check("bus_wstrb", 32'(dmem_wstrb), 32'(strb_w[3:0]));
          end
        end
        if (req_cnt == g) begin
          dmem_gnt = 1'b1; granted = 1;
          if (ld && r < 0) begin dmem_rvalid = 1'b1; data_given = 1; end
        end
        req_cnt++;
      end else if (granted && ld && !data_given) begin
        if (wait_cnt == r) begin dmem_rvalid = 1'b1; data_given = 1; end
        wait_cnt++;
      end
      dmem_rdata = dmem_rvalid ? word : $urandom();
      @(negedge clk);
      if (bus_error_out) errs++;
      if (mem_stall) begin
        stall++;
        if (reg_write_out) rw_bad = 1;
      end else begin
        finished = 1;
        check("stall_cycles", stall, exp_stall);
        check("bus_error", errs, 32'(exp_err));
        check("misaligned", 32'(misaligned_out), 32'(mis));
        check("reg_write", 32'(reg_write_out), 32'(rw && !mis && !exp_err));
        check("read_data", read_data_out, exp_rdata);
        check("rd_out", 32'(rd_out), 32'(rd));
        check("alu_out", alu_result_out, addr);
        check("mem_to_reg", 32'(mem_to_reg_out), 32'(m2r));
        check("rw_in_stall", 32'(rw_bad), 32'd0);
        check("req_seen", 32'(req_seen), 32'(aligned));
        check("req_at_done", 32'(dmem_req), 32'd0);
      end
      cyc++;
      if (!finished && cyc > 200) begin
        check("cycle_budget", cyc, exp_stall);
        finished = 1;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check("req_after", 32'(dmem_req), 32'd0);
    $display("op %0d: vld=%0d ld=%0d st=%0d f3=%0d addr=0x%08h g=%0d r=%0d stall=%0d err=%0d rdata=0x%08h",
             op_num, vld, ld, st, f3, addr, g, r, stall, errs, read_data_out);
    op_num++;
  endtask

  initial begin
    int g, r, kind, sel;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [2:0] load_f3 [5];
    load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b0; valid_in = 0; mem_read_in = 0; mem_write_in = 0; funct3_in = 0;
    alu_result_in = 0; write_data_in = 0; rd_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    run_op(1, 1, 0, 3'd0, 32'h103, 32'h0, 5'd7, 1, 1, 32'h80FF_0000, 0, 1);
    run_op(1, 0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0, 0, 0);
    run_op(1, 1, 0, 3'd2, 32'h101, 32'h0, 5'd9, 1, 1, 32'h0, 0, 0);
    run_op(1, 1, 0, 3'd2, 32'h300, 32'h0, 5'd3, 1, 1, 32'h0, NEVER, 0);
    run_op(1, 0, 0, 3'd0, 32'h42, 32'h0, 5'd5, 1, 0, 32'h0, 0, 0);
    run_op(1, 1, 0, 3'd5, 32'h402, 32'h0, 5'd4, 1, 1, 32'hBEEF_1234, 2, NEVER);
    run_op(1, 1, 0, 3'd1, 32'h502, 32'h0, 5'd6, 1, 1, 32'h8001_7FFF, 1, -1);

    // Reset while waiting for rvalid
    valid_in = 1; mem_read_in = 1; mem_write_in = 0; funct3_in = 3'd2;
    alu_result_in = 32'h40; rd_in = 5'd2; reg_write_in = 1; mem_to_reg_in = 1;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(posedge clk); #1;
    check("mid_wait_stall", 32'(mem_stall), 32'd1);
    reset = 1'b0; valid_in = 0; mem_read_in = 0;
    #1;
    check("async_req_drop", 32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(mem_stall), 32'd0);
    check("post_rst_rdata", read_data_out, 32'd0);
    check("post_rst_dmem", {dmem_addr[27:0], dmem_wstrb}, 32'd0);
    check("post_rst_wdata", dmem_wdata, 32'd0);
    check("post_rst_we", 32'(dmem_we), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("ignored_rvalid", 32'({dmem_req, mem_stall}), 32'd0);
    @(posedge clk); #1;
    $display("op %0d: reset during WAIT, rvalid ignored", op_num);
    op_num++;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom();
      if ($urandom_range(0, 2) == 0) addr[1:0] = 2'b00;
      g = ($urandom_range(0, 11) == 0) ? NEVER : $urandom_range(0, 3);
      sel = $urandom_range(0, 11);
      r = (sel == 0) ? NEVER : (sel < 3) ? -1 : $urandom_range(0, 3);
      if (kind < 4) begin
        f3 = load_f3[$urandom_range(0, 4)];
        run_op(1, 1, 0, f3, addr, $urandom(), 5'($urandom()), 1'($urandom()),
               1'($urandom()), $urandom(), g, r);
      end else if (kind < 7) begin
        f3 = 3'($urandom_range(0, 2));
        run_op(1, 0, 1, f3, addr, $urandom(), 5'($urandom()), 1'($urandom()),
               1'($urandom()), $urandom(), g, r);
      end else if (kind < 9) begin
        run_op(1, 0, 0, 3'($urandom()), addr, $urandom(), 5'($urandom()), 1'($urandom()),
               1'($urandom()), $urandom(), g, r);
      end else begin
        run_op(0, 1, 0, 3'd2, addr, $urandom(), 5'($urandom()), 1'($urandom()),
               1'($urandom()), $urandom(), g, r);
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
